// File: rtl/uart_pkg.sv
// Package uart_pkg: receiver FSM state encoding, default oversampling ratio
// and the baud divider calculation shared by the UART blocks.
package uart_pkg;

    // Receiver FSM states. PARITY is only visited when the parity build is used.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Clock cycles per sample tick, truncated; never below one cycle.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIV-1 counter producing a one-cycle
// sample tick on wrap. The clear input holds the counter at zero so the first
// tick after clear is released arrives exactly DIV cycles later.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: cleared by reset or clear, wraps at DIV-1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled serial receiver, mid-bit sampling, 2-flop input
// synchroniser. Delivers each good byte on char with a one-cycle en strobe and
// flags bad frames with a one-cycle frame_err strobe.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (default is 8N1).
//
// Strobe semantics: en and frame_err are registered, exactly one cycle wide,
// mutually exclusive, and asserted the cycle after the stop-bit sample. char
// is updated in the same cycle en rises and is otherwise held.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  char,
    output logic        en,
    output logic        frame_err,
    output logic        busy,
    output uart_state_t dbg_state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    logic          rx_meta;
    logic          rx_s;
    logic          tick;

    uart_state_t   state, state_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    char_n;
    logic          en_n;
    logic          ferr_n;
`ifdef UART_RX_PARITY_EN
    logic          par_err, par_err_n;
`endif

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Sample tick generator, held cleared while idle so ticks align to the start edge.
    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // FSM state, counters, shift register and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scnt      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            char      <= 8'h00;
            en        <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            scnt      <= scnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            char      <= char_n;
            en        <= en_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_err   <= par_err_n;
`endif
        end
    end

    // Next-state and next-output logic; every decision uses the synchronised line.
    always_comb begin
        state_n   = state;
        scnt_n    = scnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        char_n    = char;
        en_n      = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    scnt_n  = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt == S_MID) begin
                        // Mid start bit: a high line here was a glitch.
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            scnt_n    = '0;
                            bit_cnt_n = '0;
                            state_n   = DATA;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (scnt == S_END) begin
                        scnt_n  = '0;
                        shreg_n = {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt == S_END) begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        scnt_n    = '0;
                        par_err_n = (rx_s != ^shreg);
                        state_n   = STOP;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (scnt == S_END) begin
                        // Return to idle at mid stop bit so back-to-back frames are caught.
                        state_n = IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_err) begin
                                ferr_n = 1'b1;
                            end else begin
                                char_n = shreg;
                                en_n   = 1'b1;
                            end
`else
                            char_n = shreg;
                            en_n   = 1'b1;
`endif
                        end else begin
                            ferr_n = 1'b1;
                            // All-zero data with a low stop bit is a line break.
                            if (shreg == 8'h00) begin
                                state_n = BREAK;
                            end
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
